// File: rtl/aibcr3aux_osc_pkg.sv
// rtl/aibcr3aux_osc_pkg.sv - shared types, default widths and tolerance compare for the aux osc trim calibrator
package aibcr3aux_osc_pkg;

  localparam int TRIM_W_DEF = 9;
  localparam int CNT_W_DEF  = 13;
  localparam int TOL_W      = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEAS,
    ST_EVAL,
    ST_DONE
  } cal_state_t;

  // |cnt - tgt| <= tol, evaluated one bit wider so the difference never wraps
  function automatic logic within_tol(input logic [CNT_W_DEF-1:0] cnt,
                                      input logic [CNT_W_DEF-1:0] tgt,
                                      input logic [TOL_W-1:0]     tol);
    logic signed [CNT_W_DEF:0] diff;
    logic        [CNT_W_DEF:0] mag;
    diff = $signed({1'b0, cnt}) - $signed({1'b0, tgt});
    mag  = diff[CNT_W_DEF] ? $unsigned(-diff) : $unsigned(diff);
    return mag <= {{(CNT_W_DEF + 1 - TOL_W){1'b0}}, tol};
  endfunction

endpackage

// File: rtl/aibcr3aux_osc_trimcal_tmr.sv
// rtl/aibcr3aux_osc_trimcal_tmr.sv - loadable down-counter shared by settle and measurement timeout
module aibcr3aux_osc_trimcal_tmr #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/aibcr3aux_osc_trimcal.sv
// rtl/aibcr3aux_osc_trimcal.sv - SAR trim calibration of the aux oscillator against a target count
module aibcr3aux_osc_trimcal
  import aibcr3aux_osc_pkg::*;
#(
  parameter int TRIM_W      = TRIM_W_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SETTLE_CYC  = 64,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              ical_start,
  input  logic              ibypass,
  input  logic [TRIM_W-1:0] ifuse_trim,
  input  logic [CNT_W-1:0]  itarget,
  input  logic [TOL_W-1:0]  itol,
  output logic              ocnt_req,
  input  logic              icnt_done,
  input  logic [CNT_W-1:0]  icnt_val,
  output logic [TRIM_W-1:0] otrim,
  output logic              obusy,
  output logic              ocal_done,
  output logic              ocal_fail,
  output logic [CNT_W-1:0]  ocal_cnt
);

  localparam int TMR_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int IDX_W   = $clog2(TRIM_W);

  cal_state_t         state;
  logic [IDX_W-1:0]   bit_idx;
  logic               final_pass;
  logic               cal_ok;
  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_val;
  logic               tmr_expired;

  // IDLE and EVAL preload the settle time; settle expiry reloads for the measurement timeout
  assign tmr_load = (state == ST_IDLE) || (state == ST_EVAL) ||
                    ((state == ST_SETTLE) && tmr_expired);
  assign tmr_val  = (state == ST_SETTLE) ? TMR_W'(TIMEOUT_CYC - 1) : TMR_W'(SETTLE_CYC - 1);

  aibcr3aux_osc_trimcal_tmr #(.W(TMR_W)) u_tmr (
    .clk      (iclk),
    .rst      (irst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_ff @(posedge iclk) begin
    if (irst) begin
      state      <= ST_IDLE;
      otrim      <= '0;
      ocnt_req   <= 1'b0;
      obusy      <= 1'b0;
      ocal_done  <= 1'b0;
      ocal_fail  <= 1'b0;
      ocal_cnt   <= '0;
      bit_idx    <= '0;
      final_pass <= 1'b0;
      cal_ok     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!cal_ok || ibypass) otrim <= ifuse_trim;
          if (ical_start) begin
            if (ibypass) begin
              ocal_done <= 1'b1;
              ocal_fail <= 1'b0;
            end else begin
              ocal_done  <= 1'b0;
              ocal_fail  <= 1'b0;
              cal_ok     <= 1'b0;
              otrim      <= TRIM_W'(1) << (TRIM_W - 1);
              bit_idx    <= IDX_W'(TRIM_W - 1);
              final_pass <= 1'b0;
              obusy      <= 1'b1;
              state      <= ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (tmr_expired) begin
            ocnt_req <= 1'b1;
            state    <= ST_MEAS;
          end
        end
        ST_MEAS: begin
          if (icnt_done) begin
            ocal_cnt <= icnt_val;
            ocnt_req <= 1'b0;
            state    <= ST_EVAL;
          end else if (tmr_expired) begin
            ocnt_req  <= 1'b0;
            ocal_fail <= 1'b1;
            ocal_done <= 1'b1;
            otrim     <= ifuse_trim;
            state     <= ST_DONE;
          end
        end
        ST_EVAL: begin
          if (within_tol(ocal_cnt, itarget, itol)) begin
            ocal_done <= 1'b1;
            cal_ok    <= 1'b1;
            state     <= ST_DONE;
          end else if (final_pass) begin
            ocal_done <= 1'b1;
            ocal_fail <= 1'b1;
            state     <= ST_DONE;
          end else begin
            // count too high means the trim bit under test overshoots
            if (ocal_cnt > itarget) otrim[bit_idx] <= 1'b0;
            if (bit_idx != '0) begin
              otrim[bit_idx - 1'b1] <= 1'b1;
              bit_idx               <= bit_idx - 1'b1;
            end else begin
              final_pass <= 1'b1;
            end
            state <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          obusy <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aibcr3aux_osc_trimcal.sv
// tb/tb_aibcr3aux_osc_trimcal.sv - directed bench for the aux oscillator trim calibrator
module tb_aibcr3aux_osc_trimcal;

  logic        iclk = 1'b0;
  logic        irst;
  logic        ical_start;
  logic        ibypass;
  logic [8:0]  ifuse_trim;
  logic [12:0] itarget;
  logic [5:0]  itol;
  logic        ocnt_req;
  logic        icnt_done;
  logic [12:0] icnt_val;
  logic [8:0]  otrim;
  logic        obusy;
  logic        ocal_done;
  logic        ocal_fail;
  logic [12:0] ocal_cnt;

  int n_pass  = 0;
  int n_total = 0;

  bit          model_en  = 1'b1;
  bit          stray_req = 1'b0;
  logic [12:0] stray_val = 13'd0;
  int          meas_n    = 0;
  int          age       = 0;
  int          trims_log [32];

  always #5 iclk = ~iclk;

  aibcr3aux_osc_trimcal dut (
    .iclk       (iclk),
    .irst       (irst),
    .ical_start (ical_start),
    .ibypass    (ibypass),
    .ifuse_trim (ifuse_trim),
    .itarget    (itarget),
    .itol       (itol),
    .ocnt_req   (ocnt_req),
    .icnt_done  (icnt_done),
    .icnt_val   (icnt_val),
    .otrim      (otrim),
    .obusy      (obusy),
    .ocal_done  (ocal_done),
    .ocal_fail  (ocal_fail),
    .ocal_cnt   (ocal_cnt)
  );

  // oscillator model: count = 2000 + 8*trim, answered 20 cycles after the request rises
  initial begin
    icnt_done = 1'b0;
    icnt_val  = 13'd0;
    forever begin
      @(negedge iclk);
      icnt_done = 1'b0;
      if (stray_req) begin
        icnt_done = 1'b1;
        icnt_val  = stray_val;
        stray_req = 1'b0;
      end else if (ocnt_req && model_en) begin
        age++;
        if (age == 20) begin
          icnt_done = 1'b1;
          icnt_val  = 13'(2000 + 8 * int'(otrim));
          if (meas_n < 32) trims_log[meas_n] = int'(otrim);
          meas_n++;
          age = 0;
        end
      end else begin
        age = 0;
      end
    end
  end

  task automatic pulse_start();
    @(negedge iclk);
    ical_start = 1'b1;
    @(negedge iclk);
    ical_start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok, output int req_cyc);
    ok      = 1'b0;
    req_cyc = 0;
    for (int i = 0; i < max_cyc; i++) begin
      if (ocal_done) begin
        ok = 1'b1;
        break;
      end
      if (ocnt_req) req_cyc++;
      @(negedge iclk);
    end
  endtask

  task automatic test_reset();
    irst = 1'b1;
    repeat (3) @(negedge iclk);
    n_total++; if (otrim !== 9'd0)     $display("FAIL reset_otrim got %0d exp 0", otrim); else n_pass++;
    n_total++; if (ocnt_req !== 1'b0)  $display("FAIL reset_req got %0b exp 0", ocnt_req); else n_pass++;
    n_total++; if (obusy !== 1'b0)     $display("FAIL reset_busy got %0b exp 0", obusy); else n_pass++;
    n_total++; if (ocal_done !== 1'b0) $display("FAIL reset_done got %0b exp 0", ocal_done); else n_pass++;
    n_total++; if (ocal_fail !== 1'b0) $display("FAIL reset_fail got %0b exp 0", ocal_fail); else n_pass++;
    n_total++; if (ocal_cnt !== 13'd0) $display("FAIL reset_cnt got %0d exp 0", ocal_cnt); else n_pass++;
    irst = 1'b0;
    @(negedge iclk);
  endtask

  task automatic test_pass_first();
    bit ok;
    int rc;
    itarget = 13'd4048;
    itol    = 6'd4;
    meas_n  = 0;
    pulse_start();
    wait_done(5000, ok, rc);
    n_total++; if (!ok)                $display("FAIL pass1_timeout got done=%0b exp 1", ocal_done); else n_pass++;
    n_total++; if (ocal_fail !== 1'b0) $display("FAIL pass1_fail got %0b exp 0", ocal_fail); else n_pass++;
    n_total++; if (otrim !== 9'd256)   $display("FAIL pass1_trim got %0d exp 256", otrim); else n_pass++;
    n_total++; if (ocal_cnt !== 13'd4048) $display("FAIL pass1_cnt got %0d exp 4048", ocal_cnt); else n_pass++;
    n_total++; if (meas_n !== 1)       $display("FAIL pass1_nmeas got %0d exp 1", meas_n); else n_pass++;
    repeat (6) @(negedge iclk);
    n_total++; if (otrim !== 9'd256)   $display("FAIL pass1_held got %0d exp 256", otrim); else n_pass++;
    n_total++; if (obusy !== 1'b0)     $display("FAIL pass1_busy got %0b exp 0", obusy); else n_pass++;
  endtask

  task automatic test_stray_done();
    stray_val = 13'd123;
    stray_req = 1'b1;
    repeat (3) @(negedge iclk);
    n_total++; if (ocal_cnt !== 13'd4048) $display("FAIL stray_cnt got %0d exp 4048", ocal_cnt); else n_pass++;
    n_total++; if (otrim !== 9'd256)   $display("FAIL stray_trim got %0d exp 256", otrim); else n_pass++;
    n_total++; if (obusy !== 1'b0)     $display("FAIL stray_busy got %0b exp 0", obusy); else n_pass++;
    n_total++; if (ocnt_req !== 1'b0)  $display("FAIL stray_req got %0b exp 0", ocnt_req); else n_pass++;
    n_total++; if (ocal_done !== 1'b1) $display("FAIL stray_done got %0b exp 1", ocal_done); else n_pass++;
  endtask

  task automatic test_sar_converge_busy_restart();
    bit ok;
    int rc;
    int exp_seq [8] = '{256, 128, 192, 224, 240, 248, 252, 250};
    itarget = 13'd4000;
    itol    = 6'd2;
    meas_n  = 0;
    pulse_start();
    repeat (100) @(negedge iclk);
    n_total++; if (obusy !== 1'b1)     $display("FAIL conv_busy got %0b exp 1", obusy); else n_pass++;
    pulse_start();
    wait_done(8000, ok, rc);
    n_total++; if (!ok)                $display("FAIL conv_timeout got done=%0b exp 1", ocal_done); else n_pass++;
    n_total++; if (meas_n !== 8)       $display("FAIL conv_nmeas got %0d exp 8", meas_n); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (trims_log[i] !== exp_seq[i]) $display("FAIL conv_seq[%0d] got %0d exp %0d", i, trims_log[i], exp_seq[i]);
      else n_pass++;
    end
    n_total++; if (otrim !== 9'd250)   $display("FAIL conv_trim got %0d exp 250", otrim); else n_pass++;
    n_total++; if (ocal_fail !== 1'b0) $display("FAIL conv_fail got %0b exp 0", ocal_fail); else n_pass++;
    n_total++; if (ocal_cnt !== 13'd4000) $display("FAIL conv_cnt got %0d exp 4000", ocal_cnt); else n_pass++;
    repeat (4) @(negedge iclk);
  endtask

  task automatic test_sar_fail();
    bit ok;
    int rc;
    ifuse_trim = 9'd0;
    itarget    = 13'd8191;
    itol       = 6'd0;
    meas_n     = 0;
    pulse_start();
    wait_done(10000, ok, rc);
    n_total++; if (!ok)                $display("FAIL sarf_timeout got done=%0b exp 1", ocal_done); else n_pass++;
    n_total++; if (ocal_fail !== 1'b1) $display("FAIL sarf_fail got %0b exp 1", ocal_fail); else n_pass++;
    n_total++; if (otrim !== 9'd511)   $display("FAIL sarf_trim got %0d exp 511", otrim); else n_pass++;
    n_total++; if (ocal_cnt !== 13'd6088) $display("FAIL sarf_cnt got %0d exp 6088", ocal_cnt); else n_pass++;
    n_total++; if (meas_n !== 10)      $display("FAIL sarf_nmeas got %0d exp 10", meas_n); else n_pass++;
    repeat (4) @(negedge iclk);
  endtask

  task automatic test_timeout();
    bit ok;
    int rc;
    model_en   = 1'b0;
    ifuse_trim = 9'h0A5;
    itarget    = 13'd4000;
    itol       = 6'd2;
    pulse_start();
    wait_done(3000, ok, rc);
    n_total++; if (!ok)                $display("FAIL tmo_timeout got done=%0b exp 1", ocal_done); else n_pass++;
    n_total++; if (ocal_fail !== 1'b1) $display("FAIL tmo_fail got %0b exp 1", ocal_fail); else n_pass++;
    n_total++; if (otrim !== 9'h0A5)   $display("FAIL tmo_trim got %0h exp 0a5", otrim); else n_pass++;
    n_total++; if (ocnt_req !== 1'b0)  $display("FAIL tmo_req got %0b exp 0", ocnt_req); else n_pass++;
    n_total++; if (rc !== 1024)        $display("FAIL tmo_req_cycles got %0d exp 1024", rc); else n_pass++;
    model_en = 1'b1;
    repeat (4) @(negedge iclk);
  endtask

  task automatic test_reset_mid_meas();
    bit seen = 1'b0;
    pulse_start();
    for (int i = 0; i < 500; i++) begin
      if (ocnt_req) begin
        seen = 1'b1;
        break;
      end
      @(negedge iclk);
    end
    n_total++; if (!seen) $display("FAIL rmm_req got %0b exp 1", ocnt_req); else n_pass++;
    repeat (5) @(negedge iclk);
    irst = 1'b1;
    @(negedge iclk);
    n_total++; if (otrim !== 9'd0)     $display("FAIL rmm_otrim got %0d exp 0", otrim); else n_pass++;
    n_total++; if (ocnt_req !== 1'b0)  $display("FAIL rmm_req_low got %0b exp 0", ocnt_req); else n_pass++;
    n_total++; if (obusy !== 1'b0)     $display("FAIL rmm_busy got %0b exp 0", obusy); else n_pass++;
    n_total++; if (ocal_done !== 1'b0) $display("FAIL rmm_done got %0b exp 0", ocal_done); else n_pass++;
    n_total++; if (ocal_fail !== 1'b0) $display("FAIL rmm_fail got %0b exp 0", ocal_fail); else n_pass++;
    n_total++; if (ocal_cnt !== 13'd0) $display("FAIL rmm_cnt got %0d exp 0", ocal_cnt); else n_pass++;
    irst = 1'b0;
    repeat (2) @(negedge iclk);
  endtask

  task automatic test_bypass();
    int req_seen = 0;
    ibypass    = 1'b1;
    ifuse_trim = 9'h1F0;
    pulse_start();
    n_total++; if (ocal_done !== 1'b1) $display("FAIL byp_done got %0b exp 1", ocal_done); else n_pass++;
    n_total++; if (ocal_fail !== 1'b0) $display("FAIL byp_fail got %0b exp 0", ocal_fail); else n_pass++;
    n_total++; if (otrim !== 9'h1F0)   $display("FAIL byp_trim got %0h exp 1f0", otrim); else n_pass++;
    n_total++; if (obusy !== 1'b0)     $display("FAIL byp_busy got %0b exp 0", obusy); else n_pass++;
    for (int i = 0; i < 100; i++) begin
      if (ocnt_req) req_seen++;
      @(negedge iclk);
    end
    n_total++; if (req_seen !== 0)     $display("FAIL byp_req got %0d exp 0", req_seen); else n_pass++;
    ibypass = 1'b0;
  endtask

  initial begin
    irst       = 1'b1;
    ical_start = 1'b0;
    ibypass    = 1'b0;
    ifuse_trim = 9'd0;
    itarget    = 13'd0;
    itol       = 6'd0;
    test_reset();
    test_pass_first();
    test_stray_done();
    test_sar_converge_busy_restart();
    test_sar_fail();
    test_timeout();
    test_reset_mid_meas();
    test_bypass();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
